// File: rtl/fft_agu.sv
// fft_agu: read/write/twiddle address sequencer for a 512-point in-place radix-2 FFT.
// Define FFT_AGU_STALL_EN to add a `stall` input that freezes the sequence.
module fft_agu #(
  parameter int N_LOG2 = 9,
  parameter int WR_LAT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
`ifdef FFT_AGU_STALL_EN
  input  logic              stall,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr,
  output logic              phase,
  output logic [N_LOG2-1:0] twiddle_address,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_address,
  output logic [3:0]        stage
);

  localparam int         ADDR_W     = N_LOG2;
  localparam int         BF_W       = N_LOG2 - 1;
  localparam int         DLY        = WR_LAT - 1;
  localparam logic [3:0] LAST_STAGE = 4'(N_LOG2 - 1);
  localparam logic [3:0] DRAIN_INIT = 4'(WR_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [ADDR_W-1:0] rotl(input logic [ADDR_W-1:0] v, input logic [3:0] s);
    logic [2*ADDR_W-1:0] dbl;
    dbl = {v, v} << s;
    return dbl[2*ADDR_W-1:ADDR_W];
  endfunction

  // Keep the top s bits of the butterfly index; stage 0 always uses twiddle 0.
  function automatic logic [ADDR_W-1:0] twiddle_of(input logic [BF_W-1:0] b, input logic [3:0] s);
    logic [BF_W-1:0] mask;
    mask = ~({BF_W{1'b1}} >> s);
    return {1'b0, b & mask};
  endfunction

  state_t                      state_q, state_d;
  logic [3:0]                  stage_q, stage_d;
  logic [BF_W-1:0]             bfly_q, bfly_d, bfly_inc;
  logic                        ph_q, ph_d;
  logic [3:0]                  drain_q, drain_d;
  logic                        rd_vld_q, rd_vld_d;
  logic                        rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]           rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]           twid_q, twid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
  logic [DLY-1:0]              dly_en_q, dly_en_d;
  logic [DLY-1:0][ADDR_W-1:0]  dly_addr_q, dly_addr_d;

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    ph_d      = ph_q;
    drain_d   = drain_q;
    rd_vld_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    twid_d    = twid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bfly_inc  = bfly_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          stage_d   = '0;
          bfly_d    = '0;
          ph_d      = 1'b0;
          rd_vld_d  = 1'b1;
          rd_addr_d = '0;
          twid_d    = '0;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        if (!ph_q) begin
          ph_d      = 1'b1;
          rd_vld_d  = 1'b1;
          rd_addr_d = rotl({bfly_q, 1'b1}, stage_q);
        end else if (bfly_q != '1) begin
          bfly_d    = bfly_inc;
          ph_d      = 1'b0;
          rd_vld_d  = 1'b1;
          rd_addr_d = rotl({bfly_inc, 1'b0}, stage_q);
          twid_d    = twiddle_of(bfly_inc, stage_q);
        end else begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      // Hold off the next stage until the last write of this one has been presented.
      DRAIN: begin
        if (drain_q != '0) begin
          drain_d = drain_q - 4'd1;
        end else if (stage_q == LAST_STAGE) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d   = RUN;
          stage_d   = stage_q + 4'd1;
          bfly_d    = '0;
          ph_d      = 1'b0;
          rd_vld_d  = 1'b1;
          rd_addr_d = '0;
          twid_d    = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase

    dly_en_d[0]   = rd_vld_q;
    dly_addr_d[0] = rd_addr_q;
    for (int i = 1; i < DLY; i++) begin
      dly_en_d[i]   = dly_en_q[i-1];
      dly_addr_d[i] = dly_addr_q[i-1];
    end
    wr_en_d   = dly_en_q[DLY-1];
    wr_addr_d = dly_addr_q[DLY-1];
    rd_en_d   = rd_vld_d;

`ifdef FFT_AGU_STALL_EN
    // rd_vld_q keeps the held read live so the delay line resumes without a bubble.
    if (stall && state_q != IDLE) begin
      state_d    = state_q;
      stage_d    = stage_q;
      bfly_d     = bfly_q;
      ph_d       = ph_q;
      drain_d    = drain_q;
      rd_vld_d   = rd_vld_q;
      rd_addr_d  = rd_addr_q;
      twid_d     = twid_q;
      busy_d     = busy_q;
      done_d     = done_q;
      dly_en_d   = dly_en_q;
      dly_addr_d = dly_addr_q;
      wr_addr_d  = wr_addr_q;
      rd_en_d    = 1'b0;
      wr_en_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      bfly_q     <= '0;
      ph_q       <= 1'b0;
      drain_q    <= '0;
      rd_vld_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      twid_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      dly_en_q   <= '0;
      dly_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      bfly_q     <= bfly_d;
      ph_q       <= ph_d;
      drain_q    <= drain_d;
      rd_vld_q   <= rd_vld_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      twid_q     <= twid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      dly_en_q   <= dly_en_d;
      dly_addr_q <= dly_addr_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign rd_en           = rd_en_q;
  assign rd_addr         = rd_addr_q;
  assign phase           = ph_q;
  assign twiddle_address = twid_q;
  assign wr_en           = wr_en_q;
  assign wr_address      = wr_addr_q;
  assign stage           = stage_q;

endmodule
